// File: rtl/disp_scan_sched.sv
// disp_scan_sched: 8-digit multiplexed display scanner with
// frame-synchronous, round-robin update of the shown value.
module disp_scan_sched #(
    parameter int PRESCALE = 1024,
    parameter int BLANK    = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        enable,
    input  logic [2:0]  bright,
    input  logic        req_a,
    input  logic [31:0] data_a,
    input  logic        req_b,
    input  logic [31:0] data_b,
    output logic        ack_a,
    output logic        ack_b,
    output logic [7:0]  drains,
    output logic [3:0]  nibble,
    output logic        frame_tick
);

    localparam int CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int STEP = (PRESCALE - BLANK) / 8;

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t          state;
    logic [31:0]     disp;
    logic [2:0]      dig;
    logic [CW-1:0]   slot_cnt;
    logic            last;      // 0 = A granted last, 1 = B

    logic            slot_end;
    logic            boundary;
    logic [31:0]     slot_w;
    logic [31:0]     lit_end;
    logic            lit;
    logic            cap;
    logic            gnt_a;
    logic            gnt_b;

    // Slot position decode, lit window and arbitration
    always_comb begin
        slot_end = (slot_cnt == CW'(PRESCALE - 1));
        boundary = (state == SCAN) && slot_end && (dig == 3'd7);
        slot_w   = 32'(slot_cnt);
        lit_end  = 32'(BLANK) + (32'(bright) + 32'd1) * 32'(STEP);
        lit      = (slot_w >= 32'(BLANK)) && (slot_w < lit_end);
        // An ack still high blocks the next grant, so a requester
        // dropping req in response to ack is never granted twice.
        cap      = !ack_a && !ack_b && ((state == IDLE) || boundary);
        gnt_a    = cap && req_a && (!req_b || last);
        gnt_b    = cap && req_b && (!req_a || !last);
    end

    // Scan FSM with registered digit drive, grant and frame pulse
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            disp       <= '0;
            dig        <= '0;
            slot_cnt   <= '0;
            last       <= 1'b1;
            drains     <= '0;
            nibble     <= '0;
            ack_a      <= 1'b0;
            ack_b      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            ack_a      <= gnt_a;
            ack_b      <= gnt_b;
            frame_tick <= boundary && enable;
            nibble     <= disp[{dig, 2'b00} +: 4];
            drains     <= '0;
            if (gnt_a) begin
                disp <= data_a;
                last <= 1'b0;
            end else if (gnt_b) begin
                disp <= data_b;
                last <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    dig      <= '0;
                    slot_cnt <= '0;
                    if (enable) begin
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (!enable) begin
                        state    <= IDLE;
                        dig      <= '0;
                        slot_cnt <= '0;
                    end else begin
                        if (lit) begin
                            drains <= 8'd1 << dig;
                        end
                        if (slot_end) begin
                            slot_cnt <= '0;
                            dig      <= dig + 3'd1;
                        end else begin
                            slot_cnt <= slot_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_disp_scan_sched.sv
// tb_disp_scan_sched: scoreboard bench for disp_scan_sched
// (PRESCALE=16, BLANK=8), directed vectors.
module tb_disp_scan_sched;

    localparam int PS   = 16;
    localparam int BL   = 8;
    localparam int STEP = (PS - BL) / 8;
    localparam int FR   = 8 * PS;

    logic        CLK = 1'b0;
    logic        RST;
    logic        enable;
    logic [2:0]  bright;
    logic        req_a;
    logic [31:0] data_a;
    logic        req_b;
    logic [31:0] data_b;
    logic        ack_a;
    logic        ack_b;
    logic [7:0]  drains;
    logic [3:0]  nibble;
    logic        frame_tick;

    disp_scan_sched #(
        .PRESCALE(PS),
        .BLANK   (BL)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .enable    (enable),
        .bright    (bright),
        .req_a     (req_a),
        .data_a    (data_a),
        .req_b     (req_b),
        .data_b    (data_b),
        .ack_a     (ack_a),
        .ack_b     (ack_b),
        .drains    (drains),
        .nibble    (nibble),
        .frame_tick(frame_tick)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [7:0] dr;
        logic [3:0] nb;
    } lit_t;

    typedef struct {
        int   c;
        logic a;
        logic b;
        logic ft;
    } evt_t;

    lit_t lq[$];
    evt_t eq[$];
    lit_t le;
    evt_t ee;
    int   n_vec = 0;
    int   n_bad = 0;

    // Monitor: every lit digit and every ack/frame pulse must match
    // the head of its expectation queue, including the cycle number.
    always @(negedge CLK) begin
        if (drains != 8'd0) begin
            n_vec++;
            if (lq.size() == 0) begin
                n_bad++;
                $display("FAIL lit_unexpected cyc=%0d got drains=%h nibble=%h, required none",
                         cyc, drains, nibble);
            end else begin
                le = lq.pop_front();
                if (le.c != cyc || le.dr !== drains || le.nb !== nibble) begin
                    n_bad++;
                    $display("FAIL lit got cyc=%0d drains=%h nibble=%h, required cyc=%0d drains=%h nibble=%h",
                             cyc, drains, nibble, le.c, le.dr, le.nb);
                end
            end
        end
        if (ack_a || ack_b || frame_tick) begin
            n_vec++;
            if (eq.size() == 0) begin
                n_bad++;
                $display("FAIL evt_unexpected cyc=%0d got a=%b b=%b ft=%b, required none",
                         cyc, ack_a, ack_b, frame_tick);
            end else begin
                ee = eq.pop_front();
                if (ee.c != cyc || ee.a !== ack_a || ee.b !== ack_b || ee.ft !== frame_tick) begin
                    n_bad++;
                    $display("FAIL evt got cyc=%0d a=%b b=%b ft=%b, required cyc=%0d a=%b b=%b ft=%b",
                             cyc, ack_a, ack_b, frame_tick, ee.c, ee.a, ee.b, ee.ft);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %h required %h", nm, act, exp);
        end
    endtask

    // Expected lit cycles of frame f of a scan enabled in cycle k;
    // only scan indices below lim are queued.
    task automatic push_frame(input int k, input int f, input int br,
                              input logic [31:0] d, input int lim);
        lit_t e;
        for (int g = 0; g < 8; g++) begin
            for (int s = BL; s < BL + (br + 1) * STEP; s++) begin
                int i;
                i = FR * f + PS * g + s;
                if (i < lim) begin
                    e.c  = k + 2 + i;
                    e.dr = 8'(1 << g);
                    e.nb = d[4*g +: 4];
                    lq.push_back(e);
                end
            end
        end
    endtask

    task automatic push_evt(input int c, input logic a, input logic b, input logic ft);
        evt_t e;
        e.c  = c;
        e.a  = a;
        e.b  = b;
        e.ft = ft;
        eq.push_back(e);
    endtask

    task automatic chk_dark(input string nm);
        chk({nm, "_drains"}, 32'(drains), 32'd0);
        chk({nm, "_nibble"}, 32'(nibble), 32'd0);
        chk({nm, "_ack_a"}, 32'(ack_a), 32'd0);
        chk({nm, "_ack_b"}, 32'(ack_b), 32'd0);
        chk({nm, "_tick"}, 32'(frame_tick), 32'd0);
    endtask

    int c0;
    int k;
    int k2;
    int k3;

    initial begin
        RST    = 1'b1;
        enable = 1'b0;
        bright = 3'd7;
        req_a  = 1'b0;
        req_b  = 1'b0;
        data_a = '0;
        data_b = '0;
        repeat (3) tick();
        chk_dark("reset");
        RST = 1'b0;
        repeat (2) tick();

        // IDLE grant of A; req held through the ack cycle
        c0 = cyc;
        push_evt(c0 + 1, 1'b1, 1'b0, 1'b0);
        req_a  = 1'b1;
        data_a = 32'h89AB_CDEF;
        repeat (2) tick();
        req_a = 1'b0;
        repeat (4) tick();

        // Scan: bright 7, 0, 3, 7 per frame; enable drops at dig 4 slot 10
        k = cyc;
        push_frame(k, 0, 7, 32'h89AB_CDEF, 1 << 30);
        push_evt(k + 129, 1'b0, 1'b0, 1'b1);
        push_frame(k, 1, 0, 32'h89AB_CDEF, 1 << 30);
        push_evt(k + 129 + FR, 1'b0, 1'b0, 1'b1);
        push_frame(k, 2, 3, 32'h89AB_CDEF, 1 << 30);
        push_evt(k + 129 + 2 * FR, 1'b0, 1'b0, 1'b1);
        push_frame(k, 3, 7, 32'h89AB_CDEF, 3 * FR + 4 * PS + 10);
        enable = 1'b1;
        wait_cyc(k + 1 + FR + 2);
        bright = 3'd0;
        wait_cyc(k + 1 + 2 * FR + 2);
        bright = 3'd3;
        wait_cyc(k + 1 + 3 * FR + 2);
        bright = 3'd7;
        wait_cyc(k + 1 + 3 * FR + 4 * PS + 10);
        enable = 1'b0;
        repeat (5) tick();

        // Re-enable restarts at digit 0; reset lands on the ack cycle
        k2 = cyc;
        push_frame(k2, 0, 7, 32'h89AB_CDEF, FR - 1);
        enable = 1'b1;
        wait_cyc(k2 + 51);
        req_a  = 1'b1;
        data_a = 32'h1357_2468;
        wait_cyc(k2 + 129);
        chk("ack_a_before_rst", 32'(ack_a), 32'd1);
        chk("tick_before_rst", 32'(frame_tick), 32'd1);
        RST    = 1'b1;
        req_a  = 1'b0;
        enable = 1'b0;
        #1;
        chk_dark("rst_mid_ack");
        repeat (2) tick();
        RST = 1'b0;
        repeat (6) tick();
        chk_dark("after_rst");

        // Tie mid-frame: A then B at successive boundaries, then a
        // request withdrawn before its boundary
        k3 = cyc;
        push_frame(k3, 0, 7, 32'h0000_0000, 1 << 30);
        push_evt(k3 + 129, 1'b1, 1'b0, 1'b1);
        push_frame(k3, 1, 7, 32'h0123_4567, 1 << 30);
        push_evt(k3 + 129 + FR, 1'b0, 1'b1, 1'b1);
        push_frame(k3, 2, 7, 32'hFEDC_BA98, 1 << 30);
        push_evt(k3 + 129 + 2 * FR, 1'b0, 1'b0, 1'b1);
        push_frame(k3, 3, 7, 32'hFEDC_BA98, 3 * FR + 20);
        enable = 1'b1;
        wait_cyc(k3 + 41);
        req_a  = 1'b1;
        req_b  = 1'b1;
        data_a = 32'h0123_4567;
        data_b = 32'hFEDC_BA98;
        wait_cyc(k3 + 129);
        req_a = 1'b0;
        wait_cyc(k3 + 1 + 2 * FR);
        req_b = 1'b0;
        wait_cyc(k3 + 1 + 2 * FR + 3 * PS);
        req_b  = 1'b1;
        data_b = 32'h5555_5555;
        wait_cyc(k3 + 1 + 2 * FR + 5 * PS);
        req_b = 1'b0;
        wait_cyc(k3 + 1 + 3 * FR + 20);
        enable = 1'b0;
        repeat (10) tick();

        chk("lit_queue_drained", 32'(lq.size()), 32'd0);
        chk("evt_queue_drained", 32'(eq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
